// File: rtl/p2s_tx_scheduler_pkg.sv
// Shared definitions for the two-channel transmit scheduler and the serialiser bench.
package p2s_tx_scheduler_pkg;

    // FSM state encodings kept as plain constants so legacy code can compare raw values
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StGap   = 2'd2;

    localparam int unsigned DefWidth = 4;
    localparam int unsigned DefGap   = 1;

    // Counter width large enough to hold both WIDTH-1 and GAP-1, never below one bit
    function automatic int unsigned cnt_width(input int unsigned width, input int unsigned gap);
        int unsigned m;
        m = (width > gap) ? width : gap;
        if (m < 2) m = 2;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/p2s_rr_arb.sv
// Two-way round-robin arbiter: on a tie the channel that did not win last time is chosen.
module p2s_rr_arb (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic sel
);

    // Purely combinational pick; sel is meaningful only when valid is high
    always_comb begin
        valid = req0 | req1;
        sel   = (req0 & req1) ? ~last : req1;
    end

endmodule

// File: rtl/p2s_tx_scheduler.sv
// Two-channel transmit scheduler: arbitrates between requesters, captures the winning word
// and serialises it MSB-first with VO framing, an OK pulse and a programmable gap.
module p2s_tx_scheduler
    import p2s_tx_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned GAP   = DefGap
) (
    input  logic             ck,
    input  logic             reset,
    input  logic             en,
    input  logic             req0,
    input  logic [WIDTH-1:0] din0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] din1,
    output logic             ack1,
    output logic             out,
    output logic             VO,
    output logic             OK,
    output logic             busy,
    output logic             grant_id
);

    localparam int unsigned CW      = cnt_width(WIDTH, GAP);
    localparam int unsigned GapLoad = (GAP > 0) ? GAP - 1 : 0;

    logic [1:0]       state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    gcnt_q;
    logic             ack0_q, ack1_q, vo_q, ok_q, gid_q, last_q;
    logic             arb_valid, arb_sel;

    p2s_rr_arb u_arb (
        .req0  (req0),
        .req1  (req1),
        .last  (last_q),
        .valid (arb_valid),
        .sel   (arb_sel)
    );

    // Scheduler FSM, shift register and counters; ack and OK are single-cycle pulses
    always_ff @(posedge ck) begin
        if (!reset) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            vo_q    <= 1'b0;
            ok_q    <= 1'b0;
            gid_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            ok_q   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (en && arb_valid) begin
                        shreg_q <= arb_sel ? din1 : din0;
                        ack0_q  <= ~arb_sel;
                        ack1_q  <= arb_sel;
                        gid_q   <= arb_sel;
                        last_q  <= arb_sel;
                        cnt_q   <= CW'(WIDTH - 1);
                        vo_q    <= 1'b1;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        vo_q <= 1'b0;
                        ok_q <= 1'b1;
                        if (GAP == 0) begin
                            state_q <= StIdle;
                        end else begin
                            gcnt_q  <= CW'(GapLoad);
                            state_q <= StGap;
                        end
                    end
                end
                StGap: begin
                    if (gcnt_q == '0) state_q <= StIdle;
                    else              gcnt_q  <= gcnt_q - 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Registered flags drive the outputs; serial data is forced low outside the frame
    always_comb begin
        ack0     = ack0_q;
        ack1     = ack1_q;
        VO       = vo_q;
        OK       = ok_q;
        grant_id = gid_q;
        out      = vo_q & shreg_q[WIDTH-1];
        busy     = (state_q != StIdle);
    end

endmodule
